// File: rtl/bcd_counter_pkg.sv
// Shared types, segment codes and parameter helpers for the BCD day counter.
// Segment bytes are active-low: bit7 = DP, bits6:0 = g..a.
package bcd_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam int MAX_DIGITS = 6;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Packs a decimal integer into BCD, digit 0 in the low nibble.
    function automatic logic [4*MAX_DIGITS-1:0] int_to_bcd(input int unsigned value);
        logic [4*MAX_DIGITS-1:0] bcd;
        int unsigned rem;
        bcd = '0;
        rem = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return bcd;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Single BCD digit to active-low 7-segment byte, with blanking and decimal point.
module seg7_decode
    import bcd_counter_pkg::*;
(
    input  bcd_digit_t  digit,
    input  logic        dp,
    input  logic        blank,
    output logic [7:0]  seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (digit)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
        if (dp) seg[7] = 1'b0;
    end

endmodule

// File: rtl/bcd_day_counter.sv
// Prescaled up/down BCD counter between MIN_COUNT and MAX_COUNT with load and wrap pulse.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits on the display.
module bcd_day_counter
    import bcd_counter_pkg::*;
#(
    parameter int                DIGITS    = 2,
    parameter int                MIN_COUNT = 1,
    parameter int                MAX_COUNT = 99,
    parameter int                PRESCALE  = 10000000,
    parameter logic [DIGITS-1:0] DP_MASK   = '0
) (
    input  logic                  ADC_CLK_10,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [8*DIGITS-1:0]   hex,
    output logic                  tick,
    output logic                  wrap
);

    localparam int W    = 4 * DIGITS;
    localparam int PS_W = $clog2(PRESCALE);

    localparam logic [4*MAX_DIGITS-1:0] MIN_FULL = int_to_bcd(MIN_COUNT);
    localparam logic [4*MAX_DIGITS-1:0] MAX_FULL = int_to_bcd(MAX_COUNT);
    localparam logic [W-1:0]            MIN_BCD  = MIN_FULL[W-1:0];
    localparam logic [W-1:0]            MAX_BCD  = MAX_FULL[W-1:0];
    localparam logic [PS_W-1:0]         PS_LAST  = PS_W'(PRESCALE - 1);

    logic [W-1:0]      count_q;
    logic [W-1:0]      count_inc;
    logic [W-1:0]      count_dec;
    logic [PS_W-1:0]   prescaler_q;
    logic              load_ok;
    logic              carry;
    logic              borrow;
    logic [DIGITS-1:0] blank;

    assign tick      = enable && (prescaler_q == PS_LAST);
    assign count_bcd = count_q;

    // With all digits valid, packed BCD orders the same as the decimal value.
    always_comb begin
        load_ok = (load_value >= MIN_BCD) && (load_value <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_value[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    always_comb begin
        count_inc = count_q;
        count_dec = count_q;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // A valid load beats a tick in the same cycle; an invalid one is ignored entirely.
    always_ff @(posedge ADC_CLK_10 or negedge reset) begin
        if (!reset) begin
            count_q     <= MIN_BCD;
            prescaler_q <= '0;
            wrap        <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load && load_ok) begin
                count_q     <= load_value;
                prescaler_q <= '0;
            end else begin
                if (enable) begin
                    prescaler_q <= tick ? '0 : prescaler_q + PS_W'(1);
                end
                if (tick) begin
                    if (dir) begin
                        if (count_q == MAX_BCD) begin
                            count_q <= MIN_BCD;
                            wrap    <= 1'b1;
                        end else begin
                            count_q <= count_inc;
                        end
                    end else begin
                        if (count_q == MIN_BCD) begin
                            count_q <= MAX_BCD;
                            wrap    <= 1'b1;
                        end else begin
                            count_q <= count_dec;
                        end
                    end
                end
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic higher_zero;

    // Walk down from the top digit; digit 0 always shows.
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            higher_zero = higher_zero && (count_q[4*i +: 4] == 4'd0);
            blank[i]    = higher_zero;
        end
    end
`else
    always_comb begin
        blank = '0;
    end
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        seg7_decode u_seg7 (
            .digit (count_q[4*g +: 4]),
            .dp    (DP_MASK[g]),
            .blank (blank[g]),
            .seg   (hex[8*g +: 8])
        );
    end

endmodule

// File: tb/tb_bcd_day_counter.sv
// Directed self-checking bench: a 2-digit counter (PRESCALE=4) and a static 3-digit display instance.
module tb_bcd_day_counter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable, dir, load;
    logic [7:0]  load_value;
    logic [7:0]  count_bcd;
    logic [15:0] hex;
    logic        tick, wrap;

    logic        load2;
    logic [11:0] load_value2;
    logic [11:0] count_bcd2;
    logic [23:0] hex2;
    logic        tick2, wrap2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_day_counter #(
        .DIGITS    (2),
        .MIN_COUNT (1),
        .MAX_COUNT (99),
        .PRESCALE  (4),
        .DP_MASK   (2'b00)
    ) dut (
        .ADC_CLK_10 (clk),
        .reset      (reset),
        .enable     (enable),
        .dir        (dir),
        .load       (load),
        .load_value (load_value),
        .count_bcd  (count_bcd),
        .hex        (hex),
        .tick       (tick),
        .wrap       (wrap)
    );

    bcd_day_counter #(
        .DIGITS    (3),
        .MIN_COUNT (0),
        .MAX_COUNT (120),
        .PRESCALE  (2),
        .DP_MASK   (3'b010)
    ) dut2 (
        .ADC_CLK_10 (clk),
        .reset      (reset),
        .enable     (1'b0),
        .dir        (1'b1),
        .load       (load2),
        .load_value (load_value2),
        .count_bcd  (count_bcd2),
        .hex        (hex2),
        .tick       (tick2),
        .wrap       (wrap2)
    );

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [23:0] HEX2_000 = 24'hFF7FC0;
    localparam logic [23:0] HEX2_007 = 24'hFF7FF8;
`else
    localparam logic [23:0] HEX2_000 = 24'hC040C0;
    localparam logic [23:0] HEX2_007 = 24'hC040F8;
`endif

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (tick !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check(tag, 32'(tick), 32'd1);
    endtask

    task automatic advance(input string tag);
        wait_tick(tag);
        step();
    endtask

    task automatic do_load(input logic [7:0] value);
        load       = 1'b1;
        load_value = value;
        step();
        load       = 1'b0;
    endtask

    task automatic do_load2(input logic [11:0] value);
        load2       = 1'b1;
        load_value2 = value;
        step();
        load2       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; dir = 1'b1; load = 1'b0; load_value = '0;
        load2 = 1'b0; load_value2 = '0;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b0;
        #1;
        check("rst_count", 32'(count_bcd), 32'h01);
        check("rst_hex",   32'(hex),       32'hC0F9);
        check("rst_tick",  32'(tick),      32'd0);
        check("rst_wrap",  32'(wrap),      32'd0);
        check("rst_count2", 32'(count_bcd2), 32'h000);
        check("rst_hex2",   32'(hex2),       32'(HEX2_000));
        step(); step();
        check("rst_hold", 32'(count_bcd), 32'h01);

        // Release: first tick on the 4th cycle
        enable = 1'b1; reset = 1'b1;
        step(); check("tick_c1", 32'(tick), 32'd0);
        step(); check("tick_c2", 32'(tick), 32'd0);
        step(); check("tick_c3", 32'(tick), 32'd1);
        check("tick_c3_count", 32'(count_bcd), 32'h01);
        step();
        check("first_inc", 32'(count_bcd), 32'h02);
        check("first_inc_hex", 32'(hex), 32'hC0A4);
        check("first_inc_tick", 32'(tick), 32'd0);

        // Up through max and wrap
        do_load(8'h98);
        check("load98", 32'(count_bcd), 32'h98);
        advance("t98");
        check("up99", 32'(count_bcd), 32'h99);
        check("up99_hex", 32'(hex), 32'h9090);
        check("up99_wrap", 32'(wrap), 32'd0);
        advance("t99");
        check("wrap_up_count", 32'(count_bcd), 32'h01);
        check("wrap_up_pulse", 32'(wrap), 32'd1);
        step();
        check("wrap_up_clear", 32'(wrap), 32'd0);

        do_load(8'h09);
        advance("t09");
        check("carry_count", 32'(count_bcd), 32'h10);
        check("carry_hex", 32'(hex), 32'hF9C0);
        check("carry_wrap", 32'(wrap), 32'd0);

        // Down: borrow and wrap to max
        dir = 1'b0;
        advance("t10");
        check("borrow_count", 32'(count_bcd), 32'h09);
        check("borrow_hex", 32'(hex), 32'hC090);
        do_load(8'h01);
        advance("t01");
        check("wrap_dn_count", 32'(count_bcd), 32'h99);
        check("wrap_dn_pulse", 32'(wrap), 32'd1);
        step();
        check("wrap_dn_clear", 32'(wrap), 32'd0);

        // Pause while the prescaler sits at its terminal value
        do_load(8'h20);
        step(); step(); step();
        check("pre_pause_tick", 32'(tick), 32'd1);
        enable = 1'b0;
        #1;
        check("pause_tick", 32'(tick), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("pause_count", 32'(count_bcd), 32'h20);
            check("pause_tick_hold", 32'(tick), 32'd0);
        end
        enable = 1'b1;
        #1;
        check("resume_tick", 32'(tick), 32'd1);
        step();
        check("resume_count", 32'(count_bcd), 32'h19);
        check("resume_hex", 32'(hex), 32'hF990);

        // Load beats tick, and a mid-period load clears the prescaler
        dir = 1'b1;
        step(); step(); step();
        check("pre_load_tick", 32'(tick), 32'd1);
        do_load(8'h42);
        check("load_on_tick", 32'(count_bcd), 32'h42);
        check("load_on_tick_hex", 32'(hex), 32'h99A4);
        check("load_no_wrap", 32'(wrap), 32'd0);
        step();
        do_load(8'h55);
        check("load55", 32'(count_bcd), 32'h55);
        step(); step();
        check("load_clr_ps", 32'(tick), 32'd0);
        step();
        check("load_clr_tick", 32'(tick), 32'd1);
        step();
        check("inc56", 32'(count_bcd), 32'h56);
        check("inc56_hex", 32'(hex), 32'h9282);

        // Invalid loads change nothing, prescaler keeps running
        step();
        do_load(8'h3A);
        check("bad_3A", 32'(count_bcd), 32'h56);
        load = 1'b1; load_value = 8'h00;
        step();
        load = 1'b0;
        check("bad_00", 32'(count_bcd), 32'h56);
        check("bad_keep_ps", 32'(tick), 32'd1);
        step();
        check("inc57", 32'(count_bcd), 32'h57);

        // Reset mid-period
        step();
        reset = 1'b0;
        #1;
        check("mid_rst_count", 32'(count_bcd), 32'h01);
        check("mid_rst_hex", 32'(hex), 32'hC0F9);
        check("mid_rst_tick", 32'(tick), 32'd0);
        check("mid_rst_wrap", 32'(wrap), 32'd0);
        step();
        reset = 1'b1;
        step(); step();
        check("mid_rel_ps", 32'(tick), 32'd0);
        step();
        check("mid_rel_tick", 32'(tick), 32'd1);

        // Three-digit display instance: decimal point and leading zeros
        do_load2(12'h007);
        check("d2_load7", 32'(count_bcd2), 32'h007);
        check("d2_hex7", 32'(hex2), 32'(HEX2_007));
        do_load2(12'h121);
        check("d2_above_max", 32'(count_bcd2), 32'h007);
        do_load2(12'h100);
        check("d2_load100", 32'(count_bcd2), 32'h100);
        check("d2_hex100", 32'(hex2), 32'hF940C0);
        do_load2(12'h000);
        check("d2_hex0", 32'(hex2), 32'(HEX2_000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
